// File: rtl/seq_multiplier_unit.sv
// seq_multiplier_unit
// Iterative radix-2 shift-add multiplier. A 16x16 multiply is issued with a
// write-back address. The 32-bit product and that address are returned after
// WIDTH cycles. Signed operands are handled in three steps: take their
// magnitudes, multiply them as unsigned numbers, then negate the product if
// the operand signs differ.

module seq_multiplier_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  input  logic [7:0]           iDest,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult,
  output logic [7:0]           oDest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_issue;
  logic                 w_final;

  logic [2*WIDTH:0]     r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sign;
  logic [7:0]           r_destLatch;
  logic [2*WIDTH-1:0]   r_result;
  logic [7:0]           r_dest;

  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_upperSum;
  logic [2*WIDTH:0]     w_accSum;
  logic [2*WIDTH:0]     w_accShift;
  logic [2*WIDTH-1:0]   w_product;
  logic [2*WIDTH-1:0]   w_signedProduct;

  // Magnitudes: in signed mode a negative operand becomes its absolute value.
  // The most negative value maps to 2^(WIDTH-1) as an unsigned number.
  assign w_absA = (iSigned && iA[WIDTH-1]) ? (~iA + WIDTH'(1)) : iA;
  assign w_absB = (iSigned && iB[WIDTH-1]) ? (~iB + WIDTH'(1)) : iB;

  // One shift-add step: optionally add the multiplicand into the upper half,
  // then shift the whole accumulator right by one bit.
  assign w_addend        = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_upperSum      = r_acc[2*WIDTH:WIDTH] + w_addend;
  assign w_accSum        = {w_upperSum, r_acc[WIDTH-1:0]};
  assign w_accShift      = {1'b0, w_accSum[2*WIDTH:1]};
  assign w_product       = w_accShift[2*WIDTH-1:0];
  assign w_signedProduct = r_sign ? (~w_product + (2*WIDTH)'(1)) : w_product;

  assign oBusy   = w_busy;
  assign oDone   = w_done;
  assign oResult = r_result;
  assign oDest   = r_dest;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and status outputs. A new issue is accepted in IDLE and
  // in DONE. Requests that arrive during RUN are dropped.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_issue     = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_issue     = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(WIDTH-1)) begin
          w_final     = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (iStart) begin
          w_issue     = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on issue and iterate while running.
  // The result and address registers are written only on the final iteration.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_destLatch <= '0;
      r_result    <= '0;
      r_dest      <= '0;
    end else if (w_issue) begin
      r_acc       <= '0;
      r_mcand     <= w_absA;
      r_mplier    <= w_absB;
      r_cnt       <= '0;
      r_sign      <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
      r_destLatch <= iDest;
    end else if (r_state == RUN) begin
      r_acc    <= w_accShift;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_final) begin
        r_result <= w_signedProduct;
        r_dest   <= r_destLatch;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier_unit.sv
// tb_seq_multiplier_unit
// Directed test of the sequential multiplier. Expected products are
// worked out by hand.

module tb_seq_multiplier_unit;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic        iSigned;
  logic [15:0] iA;
  logic [15:0] iB;
  logic [7:0]  iDest;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;
  logic [7:0]  oDest;

  int assertions;
  int failures;
  int doneCycle;
  int firstDone;
  int secondDone;
  int pulses;
  int busyErrors;
  logic [31:0] firstResult;
  logic [31:0] capResult;
  logic [7:0]  capDest;

  seq_multiplier_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iA      (iA),
    .iB      (iB),
    .iDest   (iDest),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oResult (oResult),
    .oDest   (oDest)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic start, input logic sgn,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [7:0] dest);
    iStart  = start;
    iSigned = sgn;
    iA      = a;
    iB      = b;
    iDest   = dest;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue one operation, then wait (bounded) for oDone.
  // Records the cycle count from issue and the reported result/address.
  task automatic runOp(input logic sgn, input logic [15:0] a,
                       input logic [15:0] b, input logic [7:0] dest);
    int n;
    applyStimulus(1'b1, sgn, a, b, dest);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
    n = 0;
    doneCycle = -1;
    while (n < 40 && doneCycle < 0) begin
      tick();
      n++;
      if (oDone === 1'b1) begin
        doneCycle = n;
        capResult = oResult;
        capDest   = oDest;
      end
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    Reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
    tick();
    tick();
    checkOutput("reset_busy",   {31'd0, oBusy}, 32'd0);
    checkOutput("reset_done",   {31'd0, oDone}, 32'd0);
    checkOutput("reset_result", oResult, 32'h0);
    checkOutput("reset_dest",   {24'd0, oDest}, 32'h0);
    Reset = 1'b0;
    tick();

    // Reset during RUN aborts the operation.
    applyStimulus(1'b1, 1'b0, 16'd3, 16'd5, 8'h11);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd3, 16'd5, 8'h11);
    checkOutput("run_busy", {31'd0, oBusy}, 32'd1);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    #1;
    checkOutput("abort_busy",   {31'd0, oBusy}, 32'd0);
    checkOutput("abort_result", oResult, 32'h0);
    tick();
    tick();
    Reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (oDone === 1'b1) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);
    runOp(1'b0, 16'd3, 16'd5, 8'h11);
    checkOutput("3x5_latency", doneCycle, 16);
    checkOutput("3x5_result", capResult, 32'h0000000F);

    // Unsigned maximum: latency, single-cycle pulse, address.
    runOp(1'b0, 16'hFFFF, 16'hFFFF, 8'h0A);
    checkOutput("umax_latency", doneCycle, 16);
    checkOutput("umax_result",  capResult, 32'hFFFE0001);
    checkOutput("umax_dest",    {24'd0, capDest}, 32'h0A);
    tick();
    checkOutput("umax_pulse_end", {31'd0, oDone}, 32'd0);
    checkOutput("umax_idle_busy", {31'd0, oBusy}, 32'd0);

    // Signed corners.
    runOp(1'b1, 16'h8000, 16'h8000, 8'h01);
    checkOutput("s_min_min", capResult, 32'h40000000);
    runOp(1'b1, 16'h8000, 16'h7FFF, 8'h02);
    checkOutput("s_min_max", capResult, 32'hC0008000);
    runOp(1'b1, 16'hFFFF, 16'hFFFF, 8'h03);
    checkOutput("s_m1_m1", capResult, 32'h00000001);
    runOp(1'b1, 16'h0000, 16'hFFF9, 8'h04);
    checkOutput("s_0_m7", capResult, 32'h00000000);
    tick();

    // An issue during RUN is ignored, and input changes do not disturb the operation.
    applyStimulus(1'b1, 1'b0, 16'd100, 16'd200, 8'h33);
    tick();
    applyStimulus(1'b0, 1'b0, 16'd100, 16'd200, 8'h33);
    pulses    = 0;
    firstDone = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 3) applyStimulus(1'b1, 1'b0, 16'd2, 16'd2, 8'h44);
      if (c == 4) applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0777, 8'h55);
      if (oDone === 1'b1) begin
        pulses++;
        if (firstDone < 0) begin
          firstDone = c;
          capResult = oResult;
          capDest   = oDest;
        end
      end
    end
    checkOutput("ign_pulses",  pulses, 1);
    checkOutput("ign_latency", firstDone, 16);
    checkOutput("ign_result",  capResult, 32'h00004E20);
    checkOutput("ign_dest",    {24'd0, capDest}, 32'h33);

    // Back-to-back issue, with iStart held high through DONE.
    applyStimulus(1'b1, 1'b0, 16'd7, 16'd6, 8'h21);
    tick();
    firstDone  = -1;
    secondDone = -1;
    busyErrors = 0;
    for (int c = 1; c <= 60 && secondDone < 0; c++) begin
      tick();
      if (oBusy !== ~oDone) busyErrors++;
      if (oDone === 1'b1) begin
        if (firstDone < 0) begin
          firstDone   = c;
          firstResult = oResult;
          applyStimulus(1'b1, 1'b1, 16'hFFFD, 16'd4, 8'h22);
        end else begin
          secondDone = c;
          capResult  = oResult;
          capDest    = oDest;
        end
      end else if (firstDone > 0 && c == firstDone + 1) begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00);
      end
    end
    checkOutput("b2b_first_latency", firstDone, 16);
    checkOutput("b2b_first_result",  firstResult, 32'h0000002A);
    checkOutput("b2b_spacing",       secondDone - firstDone, 17);
    checkOutput("b2b_second_result", capResult, 32'hFFFFFFF4);
    checkOutput("b2b_second_dest",   {24'd0, capDest}, 32'h22);
    checkOutput("b2b_busy_pattern",  busyErrors, 0);

    // The result holds while idle, regardless of the inputs.
    for (int c = 0; c < 50; c++) begin
      applyStimulus(1'b0, $urandom_range(0, 1), 16'($urandom), 16'($urandom),
                    8'($urandom));
      tick();
      checkOutput("hold_result", oResult, 32'hFFFFFFF4);
      checkOutput("hold_dest",   {24'd0, oDest}, 32'h22);
      checkOutput("hold_done",   {31'd0, oDone}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_unit.md
Name: seq_multiplier_unit

Overview:
Iterative radix-2 shift-add multiplier coprocessor. It sits directly downstream of the ALU's operand-forwarding logic: the ALU issues a 16x16 multiply with a destination address, and the unit returns a 32-bit product plus that address for write-back into the 32-bit data RAM. It replaces the single-cycle combinational multiply path and supports both unsigned and signed (two's complement) operands.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-high reset.
iStart  input  1  issue request; sampled on the rising edge.
iSigned  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with iStart.
iA  input  WIDTH  multiplicand (ALU source data 1).
iB  input  WIDTH  multiplier (ALU source data 0).
iDest  input  8  write-back destination address; latched with iStart.
oBusy  output  1  high while state is RUN.
oDone  output  1  single-cycle pulse; oResult and oDest are valid in this cycle.
oResult  output  2*WIDTH  product register; holds its value until the next completion.
oDest  output  8  latched iDest of the operation reported by oDone.

Behaviour:
- Asynchronous, active-high reset. Reset forces: state=IDLE, oBusy=0, oDone=0, oResult=0, oDest=0, internal accumulator, counter and sign flag = 0. Reset asserted mid-RUN aborts the operation. No oDone is produced for it.
- States:
  - IDLE: accepts iStart.
  - RUN: WIDTH iterations.
  - DONE: one cycle, oDone=1.
- Transitions:
  - IDLE or DONE, with iStart=1 on a rising edge: latch operands, go to RUN, counter=0.
  - IDLE, iStart=0: stay in IDLE.
  - DONE, iStart=0: go to IDLE.
  - RUN: counter increments each edge. On the edge where counter reaches WIDTH-1, the final iteration completes, the result is written to oResult, and the state goes to DONE.
- Operand latch:
  - iSigned=0: magnitudes are iA and iB as-is; sign flag = 0.
  - iSigned=1: each magnitude = two's-complement absolute value as a WIDTH-bit unsigned number (0x8000 gives 32768). Sign flag = iA[MSB] XOR iB[MSB].
- Iteration: if the multiplier LSB is 1, add the multiplicand magnitude into the upper half of the 2*WIDTH+1-bit accumulator. Then shift right by 1. The multiplier shifts out LSB-first. No overflow is possible.
- Final result = sign flag ? two's-complement negation (2*WIDTH bits) of the magnitude product : the magnitude product. Negating 0 yields 0.
- Latency: iStart sampled at edge k gives oDone high in the cycle following edge k+WIDTH, i.e. exactly WIDTH cycles after issue, for 1 cycle. Throughput with back-to-back issue (iStart held during DONE) is one product per WIDTH+1 cycles.
- iStart while in RUN is ignored: no queuing, and operands are unaffected. Upstream must stall while oBusy=1.
- Input changes after the issue edge have no effect on the operation in flight.
- iStart in DONE: oDone stays 1 for that cycle (the previous result is reported) and the new operation begins on the same edge.
- oResult and oDest change only on the edge entering DONE (and on reset).

Test Plan:
- Reset during RUN: issue 3x5 unsigned, assert Reset at cycle 4 -> oBusy=0, oDone never pulses, oResult=0. After release, 3x5 -> oResult=0x0000000F.
- Unsigned max: iA=0xFFFF, iB=0xFFFF, iSigned=0, iDest=0x0A -> exactly 16 cycles after issue, oDone=1 for one cycle, oResult=0xFFFE0001, oDest=0x0A.
- Signed corners, each checked for oResult:
  - -32768 x -32768 -> 0x40000000.
  - -32768 x 32767 -> 0xC0008000.
  - -1 x -1 -> 0x00000001.
  - 0 x -7 -> 0x00000000.
- Ignored issue and input stability: pulse iStart with 2x2 while RUN on 100x200 unsigned, and change iA mid-operation -> oResult=0x00004E20 (20000), only one oDone.
- Back-to-back issue: iStart held high with 7x6, then -3x4 signed issued in the DONE cycle -> oDone pulses 17 cycles apart, results 0x0000002A then 0xFFFFFFF4, oBusy low only during the DONE cycles.
- oResult hold: after completion, leave iStart=0 for 50 cycles with random iA/iB -> oResult and oDest unchanged, oDone=0.
